// File: rtl/spi_cmd_slave_if.sv
// spi_cmd_slave_if: SPI pins plus register-file and memory-read bus of the
// SPI command slave. The slave modport is the engine side; the master modport
// is the pad/register-file/memory side.
interface spi_cmd_slave_if;
  logic       ss_i;
  logic       sck_i;
  logic       mosi_i;
  logic       miso_o;
  logic       miso_oe_o;
  logic [6:0] reg_addr;
  logic [7:0] reg_data_o;
  logic [7:0] reg_data_i;
  logic       reg_rd;
  logic       reg_wr;
  logic       mem_rd_ena;
  logic [7:0] mem_data_out;
  logic       mem_ena_out;
  logic [2:0] block_size_o;
  logic [1:0] rs_mode_o;
  logic       underrun_o;

  modport slave (
    input  ss_i, sck_i, mosi_i, reg_data_i, mem_data_out, mem_ena_out,
    output miso_o, miso_oe_o, reg_addr, reg_data_o, reg_rd, reg_wr,
           mem_rd_ena, block_size_o, rs_mode_o, underrun_o
  );

  modport master (
    output ss_i, sck_i, mosi_i, reg_data_i, mem_data_out, mem_ena_out,
    input  miso_o, miso_oe_o, reg_addr, reg_data_o, reg_rd, reg_wr,
           mem_rd_ena, block_size_o, rs_mode_o, underrun_o
  );
endinterface

// File: rtl/spi_cmd_slave.sv
// spi_cmd_slave: SPI mode-0 slave command engine, fully oversampled in clk.
// Command 0x74 = single register read/write, 0x75 = mass memory read with a
// small prefetch buffer. The mass-read path (0x75 decode, prefetch buffer,
// underrun flag, block_size/rs_mode capture) exists only when the macro
// SPI_CMD_MASS_EN is defined; otherwise 0x75 is an unknown command and the
// memory-side outputs are tied low.
module spi_cmd_slave #(
  parameter int SYNC_STAGES = 2,
  parameter int PF_DEPTH    = 2
) (
  input  logic           clk,
  input  logic           reset_n,
  spi_cmd_slave_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_ADDR, S_WDATA, S_RDUMMY, S_RDATA,
    S_MCFG, S_MDUMMY, S_MSTREAM, S_DISCARD
  } state_t;

  // ---------------------------------------------------------------- sync
  logic [SYNC_STAGES-1:0] r_ss_sync;
  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sck_d;
  logic                   w_ss;
  logic                   w_sck;
  logic                   w_mosi;
  logic                   w_sck_rise;
  logic                   w_sck_fall;

  // Bring the SPI pins into clk; SS idles high so reset parks it deselected.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ss_sync   <= '1;
      r_sck_sync  <= '0;
      r_mosi_sync <= '0;
      r_sck_d     <= 1'b0;
    end else begin
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], bus.ss_i};
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], bus.sck_i};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.mosi_i};
      r_sck_d     <= r_sck_sync[SYNC_STAGES-1];
    end
  end

  assign w_ss       = r_ss_sync[SYNC_STAGES-1];
  assign w_sck      = r_sck_sync[SYNC_STAGES-1];
  assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
  assign w_sck_rise = w_sck & ~r_sck_d;
  assign w_sck_fall = ~w_sck & r_sck_d;

  // ------------------------------------------------------ shared FSM state
  state_t     r_state;
  logic [2:0] r_bit_cnt;
  logic [6:0] r_shift;
  logic [7:0] r_tx;
  logic [7:0] r_rd_data;
  logic       r_cap_pend;
  logic [6:0] r_reg_addr;
  logic [7:0] r_reg_data;
  logic       r_reg_rd;
  logic       r_reg_wr;
  logic       r_miso;
  logic       r_miso_oe;
  logic [7:0] w_byte;
  logic       w_byte_done;
  logic [7:0] w_load_byte;

  // The byte being completed includes the bit sampled on this rise.
  assign w_byte      = {r_shift, w_mosi};
  assign w_byte_done = w_sck_rise && (r_bit_cnt == 3'd7);

`ifdef SPI_CMD_MASS_EN
  // -------------------------------------------------- mass-read prefetch
  localparam int PW = $clog2(PF_DEPTH);

  logic [7:0]    r_pf_mem [PF_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;
  logic          r_pf_en;
  logic          r_pend;
  logic          r_mem_rd;
  logic          r_underrun;
  logic [2:0]    r_block_size;
  logic [1:0]    r_rs_mode;
  logic          w_empty;
  logic          w_full;
  logic          w_mcfg_done;
  logic          w_req;
  logic          w_push;
  logic          w_pop;
  logic          w_pop_hit;
  logic [7:0]    w_pop_data;

  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == (PW+1)'(PF_DEPTH));
  assign w_mcfg_done = !w_ss && (r_state == S_MCFG) && w_byte_done;
  // Requesting on the MCFG completion itself gives the 1-clk first request.
  assign w_req       = !w_ss && (r_pf_en || w_mcfg_done) && !w_full && !r_pend;
  // Responses only count while a request is ours; stale ones after an abort drop.
  assign w_push      = r_pend && bus.mem_ena_out;
  assign w_pop       = !w_ss && (r_state == S_MSTREAM) && w_sck_fall && (r_bit_cnt == 3'd0);
  assign w_pop_hit   = w_pop && !w_empty;
  assign w_pop_data  = w_empty ? 8'h00 : r_pf_mem[r_rd_ptr];

  // Prefetch storage; contents need no reset since r_count gates every read.
  always_ff @(posedge clk) begin
    if (w_push && !w_ss) r_pf_mem[r_wr_ptr] <= bus.mem_data_out;
  end

  // Prefetch control: single outstanding request, flush on deselect.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_pf_en      <= 1'b0;
      r_pend       <= 1'b0;
      r_mem_rd     <= 1'b0;
      r_underrun   <= 1'b0;
      r_block_size <= '0;
      r_rs_mode    <= '0;
    end else if (w_ss) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_pf_en  <= 1'b0;
      r_pend   <= 1'b0;
      r_mem_rd <= 1'b0;
    end else begin
      r_mem_rd <= w_req;
      if (w_req)       r_pend <= 1'b1;
      else if (w_push) r_pend <= 1'b0;
      if (w_mcfg_done) begin
        r_pf_en      <= 1'b1;
        r_block_size <= w_byte[6:4];
        r_rs_mode    <= w_byte[3:2];
      end
      // First selected cycle of a frame clears the sticky flag.
      if (r_state == S_IDLE) r_underrun <= 1'b0;
      if (w_pop && w_empty)  r_underrun <= 1'b1;
      if (w_push)    r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_hit) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop_hit})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.mem_rd_ena   = r_mem_rd;
  assign bus.underrun_o   = r_underrun;
  assign bus.block_size_o = r_block_size;
  assign bus.rs_mode_o    = r_rs_mode;
  assign w_load_byte      = (r_state == S_MSTREAM) ? w_pop_data : r_rd_data;
`else
  logic w_unused_mem;
  assign w_unused_mem     = ^{bus.mem_data_out, bus.mem_ena_out, PF_DEPTH[0]};
  assign bus.mem_rd_ena   = 1'b0;
  assign bus.underrun_o   = 1'b0;
  assign bus.block_size_o = '0;
  assign bus.rs_mode_o    = '0;
  assign w_load_byte      = r_rd_data;
`endif

  // Command FSM: shift on rises, decode at byte boundaries, drive MISO on falls.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_tx       <= '0;
      r_rd_data  <= '0;
      r_cap_pend <= 1'b0;
      r_reg_addr <= '0;
      r_reg_data <= '0;
      r_reg_rd   <= 1'b0;
      r_reg_wr   <= 1'b0;
      r_miso     <= 1'b0;
      r_miso_oe  <= 1'b0;
    end else begin
      r_reg_rd   <= 1'b0;
      r_reg_wr   <= 1'b0;
      // Register file answers one clk after the strobe; grab it then.
      r_cap_pend <= r_reg_rd;
      if (r_cap_pend) r_rd_data <= bus.reg_data_i;

      if (w_ss) begin
        // Deselect beats any byte completing in the same clk.
        r_state   <= S_IDLE;
        r_bit_cnt <= '0;
        r_tx      <= '0;
        r_miso    <= 1'b0;
        r_miso_oe <= 1'b0;
      end else if (r_state == S_IDLE) begin
        r_state   <= S_CMD;
        r_bit_cnt <= '0;
        r_miso    <= 1'b0;
        r_miso_oe <= 1'b1;
      end else begin
        if (w_sck_rise) begin
          r_shift   <= w_byte[6:0];
          r_bit_cnt <= r_bit_cnt + 3'd1;
        end

        if (w_byte_done) begin
          case (r_state)
            S_CMD: begin
              if (w_byte == 8'h74)      r_state <= S_ADDR;
`ifdef SPI_CMD_MASS_EN
              else if (w_byte == 8'h75) r_state <= S_MCFG;
`endif
              else                      r_state <= S_DISCARD;
            end
            S_ADDR: begin
              r_reg_addr <= w_byte[6:0];
              if (w_byte[7]) r_state <= S_WDATA;
              else begin
                r_reg_rd <= 1'b1;
                r_state  <= S_RDUMMY;
              end
            end
            S_WDATA: begin
              r_reg_data <= w_byte;
              r_reg_wr   <= 1'b1;
              r_state    <= S_DISCARD;
            end
            S_RDUMMY: r_state <= S_RDATA;
            S_RDATA:  r_state <= S_DISCARD;
`ifdef SPI_CMD_MASS_EN
            S_MCFG:   r_state <= S_MDUMMY;
            S_MDUMMY: r_state <= S_MSTREAM;
`endif
            default: ;
          endcase
        end

        if (w_sck_fall) begin
          case (r_state)
            // The fall at bit 0 starts a byte: load a fresh one, else shift.
            S_RDATA, S_MSTREAM: begin
              if (r_bit_cnt == 3'd0) begin
                r_miso <= w_load_byte[7];
                r_tx   <= {w_load_byte[6:0], 1'b0};
              end else begin
                r_miso <= r_tx[7];
                r_tx   <= {r_tx[6:0], 1'b0};
              end
            end
            default: r_miso <= 1'b0;
          endcase
        end
      end
    end
  end

  assign bus.miso_o     = r_miso;
  assign bus.miso_oe_o  = r_miso_oe;
  assign bus.reg_addr   = r_reg_addr;
  assign bus.reg_data_o = r_reg_data;
  assign bus.reg_rd     = r_reg_rd;
  assign bus.reg_wr     = r_reg_wr;

endmodule
